filter_svf_mc: RTL

Time-multiplexed, parametrised state-variable filter serving `CH` independent channels with one shared multiplier. It sits between the voice mixer and the output DAC path, one channel per SID instance. Compared with the single-channel filter, it adds per-channel register banks, a mode-select mixer and a synchronous reset. All LP/BP/HP outputs are aligned and registered in the same cycle, and a busy/overrun indication is provided.

---
 rtl/filter_svf_mc_if.sv | 31 +++
 rtl/filter_svf_mc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/filter_svf_mc_if.sv
// Register-write, sample and result bundle for the multi-channel state-variable filter.
// Signal names are kept identical to the original flat port list.
interface filter_svf_mc_if #(
    parameter int W   = 16,
    parameter int CH  = 2,
    parameter int CHW = (CH > 1) ? $clog2(CH) : 1
);
    logic              clkEn;
    logic [CH*W-1:0]   iIn;
    logic              iWE;
    logic [CHW-1:0]    iCh;
    logic [4:0]        iAddr;
    logic [7:0]        iData;
    logic [CH*W-1:0]   oLP;
    logic [CH*W-1:0]   oBP;
    logic [CH*W-1:0]   oHP;
    logic [CH*W-1:0]   oMix;
    logic              oValid;
    logic              oBusy;
    logic              oOverrun;

    modport master (
        output clkEn, iIn, iWE, iCh, iAddr, iData,
        input  oLP, oBP, oHP, oMix, oValid, oBusy, oOverrun
    );

    modport slave (
        input  clkEn, iIn, iWE, iCh, iAddr, iData,
        output oLP, oBP, oHP, oMix, oValid, oBusy, oOverrun
    );
endinterface

// File: rtl/filter_svf_mc.sv
// Time-multiplexed state-variable filter: CH channels share one W+1 x CW multiplier,
// four cycles per channel, with per-channel cutoff smoothing and a mode-select mixer.
module filter_svf_mc #(
    parameter int W  = 16,
    parameter int CW = 16,
    parameter int CH = 2
) (
    input logic            clk,
    input logic            rst,
    filter_svf_mc_if.slave bus
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic signed [W+2:0] S_MAX = {3'b000, {W{1'b1}}};
    localparam logic signed [W+2:0] S_MIN = {3'b111, {W{1'b0}}};
    localparam logic signed [W+2:0] O_MAX = {4'b0000, {(W-1){1'b1}}};
    localparam logic signed [W+2:0] O_MIN = {4'b1111, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SA, SB, SC, SD} state_t;

    state_t state_q, state_d;

    logic [CHW-1:0]     c_q;
    logic signed [W-1:0] in_q   [CH];
    logic signed [W:0]   low_q  [CH];
    logic signed [W:0]   band_q [CH];
    logic signed [W:0]   high_q [CH];
    logic [CW-1:0]       lag0_q [CH];
    logic [CW-1:0]       lag1_q [CH];
    logic [10:0]         freq_q [CH];
    logic [3:0]          res_q  [CH];
    logic [2:0]          mode_q [CH];
    logic signed [W:0]   p_q;
    logic [CH*W-1:0]     lp_q, bp_q, hp_q, mix_q;
    logic                valid_q, overrun_q;

    logic                accept, drop, load_p, last;
    logic signed [W:0]   mul_a;
    logic [CW-1:0]       mul_b;
    logic signed [W+CW+1:0] prod;
    logic signed [W:0]   p_next;
    logic signed [W:0]   low_new, h_val, band_new;
    logic signed [W+2:0] mix_sum;

    function automatic logic signed [W+2:0] ext(input logic signed [W:0] x);
        return (W+3)'(x);
    endfunction

    function automatic logic signed [W:0] sat(input logic signed [W+2:0] x);
        if (x > S_MAX)      return (W+1)'(S_MAX);
        else if (x < S_MIN) return (W+1)'(S_MIN);
        else                return (W+1)'(x);
    endfunction

    function automatic logic signed [W-1:0] clip(input logic signed [W+2:0] x);
        if (x > O_MAX)      return W'(O_MAX);
        else if (x < O_MIN) return W'(O_MIN);
        else                return W'(x);
    endfunction

    // (freq+1) << (CW-11) reaches 2^CW for freq = 0x7FF, hence the CW+1-bit intermediate.
    function automatic logic [CW-1:0] cut_target(input logic [10:0] f);
        logic [CW:0] t;
        t = (CW+1)'(f) + (CW+1)'(1);
        t = t << (CW - 11);
        return CW'(t >> 2);
    endfunction

    function automatic logic [CW-1:0] res_coef(input logic [3:0] r);
        logic [CW:0] t;
        t = ((CW+1)'(3) << (CW - 2)) - (CW+1)'(1) - ((CW+1)'(r) << (CW - 5));
        return CW'(t);
    endfunction

    function automatic logic [CW-1:0] lag_avg(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW:1];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        load_p  = 1'b0;
        mul_a   = '0;
        mul_b   = '0;
        last    = (c_q == CHW'(CH - 1));
        drop    = bus.clkEn && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.clkEn) begin
                    accept  = 1'b1;
                    state_d = SA;
                end
            end
            SA: begin
                mul_a   = band_q[c_q];
                mul_b   = lag1_q[c_q];
                load_p  = 1'b1;
                state_d = SB;
            end
            SB: begin
                mul_a   = band_q[c_q];
                mul_b   = res_coef(res_q[c_q]);
                load_p  = 1'b1;
                state_d = SC;
            end
            SC: begin
                mul_a   = h_val;
                mul_b   = lag1_q[c_q];
                load_p  = 1'b1;
                state_d = SD;
            end
            SD: state_d = last ? IDLE : SA;
            default: state_d = IDLE;
        endcase
    end

    // Coefficient is unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        prod   = (W+CW+2)'(mul_a) * (W+CW+2)'($signed({1'b0, mul_b}));
        p_next = (W+1)'(prod >>> CW);
    end

    always_comb begin
        low_new  = sat(ext(low_q[c_q]) + ext(p_q));
        h_val    = sat((W+3)'(in_q[c_q]) - ext(low_q[c_q]) - ext(p_q));
        band_new = sat(ext(band_q[c_q]) + ext(p_q));
        mix_sum  = '0;
        if (mode_q[c_q][0]) mix_sum = mix_sum + ext(low_q[c_q]);
        if (mode_q[c_q][1]) mix_sum = mix_sum + ext(band_new);
        if (mode_q[c_q][2]) mix_sum = mix_sum + ext(high_q[c_q]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q       <= '0;
            p_q       <= '0;
            lp_q      <= '0;
            bp_q      <= '0;
            hp_q      <= '0;
            mix_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int unsigned k = 0; k < CH; k++) begin
                in_q[k]   <= '0;
                low_q[k]  <= '0;
                band_q[k] <= '0;
                high_q[k] <= '0;
                lag0_q[k] <= '0;
                lag1_q[k] <= '0;
                freq_q[k] <= '0;
                res_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            if (drop) overrun_q <= 1'b1;

            if (bus.iWE) begin
                for (int unsigned k = 0; k < CH; k++) begin
                    if (bus.iCh == CHW'(k)) begin
                        case (bus.iAddr)
                            5'h15:   freq_q[k][2:0]  <= bus.iData[2:0];
                            5'h16:   freq_q[k][10:3] <= bus.iData;
                            5'h17:   res_q[k]        <= bus.iData[7:4];
                            5'h18:   mode_q[k]       <= bus.iData[6:4];
                            default: ;
                        endcase
                    end
                end
            end

            // lag1 averages with the pre-update lag0, giving a two-stage lag on the cutoff.
            if (accept) begin
                c_q <= '0;
                for (int unsigned k = 0; k < CH; k++) begin
                    in_q[k]   <= bus.iIn[k*W +: W];
                    lag0_q[k] <= lag_avg(lag0_q[k], cut_target(freq_q[k]));
                    lag1_q[k] <= lag_avg(lag1_q[k], lag0_q[k]);
                end
            end

            if (load_p) p_q <= p_next;

            case (state_q)
                SB: low_q[c_q]  <= low_new;
                SC: high_q[c_q] <= h_val;
                SD: begin
                    band_q[c_q]          <= band_new;
                    lp_q[c_q*W +: W]     <= clip(ext(low_q[c_q]));
                    bp_q[c_q*W +: W]     <= clip(ext(band_new));
                    hp_q[c_q*W +: W]     <= clip(ext(high_q[c_q]));
                    mix_q[c_q*W +: W]    <= clip(mix_sum);
                    if (last) valid_q <= 1'b1;
                    else      c_q     <= c_q + CHW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.oLP      = lp_q;
    assign bus.oBP      = bp_q;
    assign bus.oHP      = hp_q;
    assign bus.oMix     = mix_q;
    assign bus.oValid   = valid_q;
    assign bus.oBusy    = (state_q != IDLE);
    assign bus.oOverrun = overrun_q;
endmodule
